// File: rtl/snoopy_arbiter_pkg.sv
// Shared types and helpers for the snoopy bus arbiter.
package snoopy_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANTED,
      TURNAROUND
   } ArbiterState;

   // Round-robin successor of a device index, wrapping at n (n need not be a power of two).
   function automatic int unsigned nextPointer(input int unsigned pointer, input int unsigned n);
      return (pointer + 32'd1 >= n) ? 32'd0 : pointer + 32'd1;
   endfunction

endpackage

// File: rtl/snoopy_bus_arbiter_rr_priority_select.sv
// Combinational round-robin selector: first set request bit at or after pointer, modulo NUM_DEVICES.
module rr_priority_select #(
   parameter int NUM_DEVICES = 4,
   parameter int ID_WIDTH    = $clog2(NUM_DEVICES)
) (
   input  logic [NUM_DEVICES-1:0] request,
   input  logic [ID_WIDTH-1:0]    pointer,
   output logic [ID_WIDTH-1:0]    winner,
   output logic                   valid
);

   localparam int SEL_WIDTH = $clog2(2 * NUM_DEVICES);
   localparam logic [ID_WIDTH:0] DEVICE_COUNT = (ID_WIDTH + 1)'(NUM_DEVICES);

   logic [2*NUM_DEVICES-1:0] doubled;
   logic [NUM_DEVICES-1:0]   rotated;
   logic [ID_WIDTH-1:0]      offset;
   logic [ID_WIDTH:0]        sum;
   logic                     found;

   assign doubled = {request, request};
   assign valid   = |request;

   // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
   always_comb begin
      rotated = '0;
      offset  = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
         rotated[i] = doubled[SEL_WIDTH'(i) + SEL_WIDTH'(pointer)];
      end
      for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
         if (rotated[i] && !found) begin
            found  = 1'b1;
            offset = ID_WIDTH'(i);
         end
      end
      sum = {1'b0, pointer} + {1'b0, offset};
      if (sum >= DEVICE_COUNT) begin
         sum = sum - DEVICE_COUNT;
      end
      winner = sum[ID_WIDTH-1:0];
   end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin arbiter for the shared snoopy bus.
// Grant is held for the whole transaction, followed by one dead turnaround cycle.
// Optional macro SNOOPY_ARBITER_TENURE_LIMIT_EN: preempt an owner after MAX_TENURE cycles
// when another device is waiting.
module snoopy_bus_arbiter
   import snoopy_arbiter_pkg::*;
#(
   parameter int NUM_DEVICES = 4,
   parameter int ID_WIDTH    = $clog2(NUM_DEVICES),
   parameter int MAX_TENURE  = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_DEVICES-1:0] request,
   output logic [NUM_DEVICES-1:0] grant,
   output logic                   busy,
   output logic [ID_WIDTH-1:0]    grantedId
);

   if (NUM_DEVICES < 2 || MAX_TENURE < 2) begin : g_bad_params
      $error("snoopy_bus_arbiter: NUM_DEVICES and MAX_TENURE must both be >= 2");
   end

   ArbiterState              state, stateNext;
   logic [ID_WIDTH-1:0]      pointer, pointerNext;
   logic [NUM_DEVICES-1:0]   grantNext;
   logic                     busyNext;
   logic [ID_WIDTH-1:0]      idNext;
   logic [ID_WIDTH-1:0]      winner;
   logic                     winnerValid;
   logic                     tenureExpired;

   rr_priority_select #(
      .NUM_DEVICES(NUM_DEVICES),
      .ID_WIDTH   (ID_WIDTH)
   ) u_select (
      .request(request),
      .pointer(pointer),
      .winner (winner),
      .valid  (winnerValid)
   );

`ifdef SNOOPY_ARBITER_TENURE_LIMIT_EN
   localparam int TENURE_WIDTH = $clog2(MAX_TENURE + 1);
   localparam logic [TENURE_WIDTH-1:0] TENURE_LAST = TENURE_WIDTH'(MAX_TENURE - 1);

   logic [TENURE_WIDTH-1:0] tenure;

   // Counts cycles of the current tenure; parks at its last value while nobody else wants the bus.
   always_ff @(posedge clock) begin
      if (!reset || state != GRANTED) begin
         tenure <= '0;
      end else if (tenure != TENURE_LAST) begin
         tenure <= tenure + TENURE_WIDTH'(1);
      end
   end

   assign tenureExpired = (state == GRANTED) && (tenure == TENURE_LAST) && (|(request & ~grant));
`else
   assign tenureExpired = 1'b0;
`endif

   // State, pointer and registered outputs; reset wins even mid-transaction.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         pointer   <= '0;
         grant     <= '0;
         busy      <= 1'b0;
         grantedId <= '0;
      end else begin
         state     <= stateNext;
         pointer   <= pointerNext;
         grant     <= grantNext;
         busy      <= busyNext;
         grantedId <= idNext;
      end
   end

   // Next-state and next-output decode: arbitrate in IDLE, hold in GRANTED, one dead cycle after.
   always_comb begin
      stateNext   = state;
      pointerNext = pointer;
      grantNext   = grant;
      busyNext    = busy;
      idNext      = grantedId;
      case (state)
         IDLE: begin
            grantNext = '0;
            busyNext  = 1'b0;
            idNext    = '0;
            if (winnerValid) begin
               grantNext   = NUM_DEVICES'(1) << winner;
               busyNext    = 1'b1;
               idNext      = winner;
               pointerNext = ID_WIDTH'(nextPointer(32'(winner), NUM_DEVICES));
               stateNext   = GRANTED;
            end
         end
         GRANTED: begin
            if (!request[grantedId] || tenureExpired) begin
               grantNext = '0;
               busyNext  = 1'b0;
               idNext    = '0;
               stateNext = TURNAROUND;
            end
         end
         TURNAROUND: begin
            grantNext = '0;
            busyNext  = 1'b0;
            idNext    = '0;
            stateNext = IDLE;
         end
         default: begin
            grantNext = '0;
            busyNext  = 1'b0;
            idNext    = '0;
            stateNext = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Self-checking bench for snoopy_bus_arbiter (NUM_DEVICES=4, MAX_TENURE=4).
module tb_snoopy_bus_arbiter;

   localparam int N    = 4;
   localparam int MAXT = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] request = '0;
   logic [N-1:0] grant;
   logic         busy;
   logic [1:0]   grantedId;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   snoopy_bus_arbiter #(
      .NUM_DEVICES(N),
      .MAX_TENURE (MAXT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .request  (request),
      .grant    (grant),
      .busy     (busy),
      .grantedId(grantedId)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the bus, whose turn is next, and whether a dead cycle is pending.
   int mOwner = -1;
   int mPtr   = 0;
   int mHeld  = 0;
   bit mGap   = 1'b0;
   bit mReset = 1'b1;
   bit mForce;

   always @(posedge clock) begin
      if (!reset) begin
         mOwner = -1;
         mPtr   = 0;
         mGap   = 1'b0;
         mReset = 1'b1;
      end else begin
         mReset = 1'b0;
         if (mOwner >= 0) begin
            mHeld++;
            mForce = 1'b0;
`ifdef SNOOPY_ARBITER_TENURE_LIMIT_EN
            mForce = (mHeld >= MAXT) && ((request & ~(4'b0001 << mOwner)) != 4'b0000);
`endif
            if (!request[mOwner] || mForce) begin
               mOwner = -1;
               mGap   = 1'b1;
            end
         end else if (mGap) begin
            mGap = 1'b0;
         end else begin
            for (int k = 0; k < N; k++) begin
               int d;
               d = (mPtr + k) % N;
               if (request[d]) begin
                  mOwner = d;
                  mPtr   = (d + 1) % N;
                  mHeld  = 0;
                  break;
               end
            end
         end
      end
   end

   // Every cycle: DUT outputs against the model.
   always @(negedge clock) begin
      logic [3:0] expGrant;
      expGrant = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
      check("model_grant", grant, expGrant);
      check("model_busy", busy, (mOwner >= 0));
      if (mOwner >= 0) check("model_grantedId", grantedId, mOwner);
      else if (mReset) check("model_grantedId_reset", grantedId, 0);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Waits (bounded) for a grant to appear; reports how many grant-free cycles were seen.
   task automatic waitGrant(input logic [3:0] exp, input string name, output int zeros);
      zeros = 0;
      while (grant == 4'b0000 && zeros < 12) begin
         zeros++;
         @(negedge clock);
      end
      check(name, grant, exp);
   endtask

   initial begin
      int zeros;
      int held;

      // Reset held low with all devices requesting.
      reset   = 1'b0;
      request = 4'b1111;
      cyc(2);
      check("reset_grant", grant, 4'b0000);
      check("reset_busy", busy, 1'b0);
      check("reset_id", grantedId, 2'd0);

      // Single requester: one-cycle latency, release, one dead cycle.
      reset   = 1'b1;
      request = 4'b0000;
      cyc(1);
      request = 4'b0100;
      cyc(1);
      check("single_grant", grant, 4'b0100);
      check("single_id", grantedId, 2'd2);
      request = 4'b0000;
      cyc(1);
      check("single_release", grant, 4'b0000);

      // Pointer sits at 3: device 3 beats device 0, then the pointer wraps to device 0.
      request = 4'b1001;
      waitGrant(4'b1000, "wrap_first", zeros);
      check("wrap_first_id", grantedId, 2'd3);
      check("turnaround_ignored", zeros, 2);
      request = 4'b0001;
      cyc(1);
      waitGrant(4'b0001, "wrap_second", zeros);
      check("wrap_gap", zeros, 2);

      // Device 1 owns the bus when reset hits; afterwards the pointer is back at 0.
      request = 4'b0010;
      cyc(1);
      waitGrant(4'b0010, "pre_reset_grant", zeros);
      cyc(1);
      reset = 1'b0;
      cyc(1);
      check("midreset_grant", grant, 4'b0000);
      check("midreset_busy", busy, 1'b0);
      check("midreset_id", grantedId, 2'd0);
      reset   = 1'b1;
      request = 4'b0011;
      cyc(1);
      check("post_reset_grant", grant, 4'b0001);

      // Everyone requesting, each owner holds three cycles: 0,1,2,3,0 with a two-cycle gap.
      request = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         int dev;
         dev = i % N;
         if (i > 0) begin
            waitGrant(4'(1 << dev), "rr_order", zeros);
            check("rr_gap", zeros, 2);
         end
         cyc(2);
         request[dev] = 1'b0;
         cyc(1);
         request[dev] = 1'b1;
      end

      // Long tenure by device 0 while device 2 waits.
      request = 4'b0000;
      cyc(3);
      request = 4'b0001;
      cyc(1);
      check("tenure_start", grant, 4'b0001);
      request = 4'b0101;
      held = 1;
      while (held < 30) begin
         cyc(1);
         if (grant == 4'b0001) held++;
         else break;
      end
`ifdef SNOOPY_ARBITER_TENURE_LIMIT_EN
      check("tenure_preempt", held, MAXT);
      waitGrant(4'b0100, "tenure_next", zeros);
      check("tenure_gap", zeros, 2);
`else
      check("tenure_hold", held, 30);
`endif

      request = 4'b0000;
      cyc(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
